// File: rtl/burst_mem_responder.sv
// burst_mem_responder: memory-side end of the mp4 cache-line port.
// A request is accepted in IDLE, waits LATENCY cycles, and then moves one
// 256-bit line as four 64-bit beats to or from an on-chip line store.
// Optional protocol checker: define BURST_MEM_PROTO_CHECK_EN.
//
// Handshake: the initiator holds mem_read or mem_write high until the transaction ends.
// mem_resp is high for exactly four consecutive cycles, one per beat.
// On a read, mem_rdata carries beat k in the k-th mem_resp cycle.
// On a write, mem_wdata must hold beat k in the k-th mem_resp cycle.
// The request must drop before another transaction is accepted.
// dbg_state exposes the FSM encoding: 0 IDLE, 1 WAIT, 2 BURST, 3 DONE.
module burst_mem_responder #(
   parameter int unsigned LINE_IDX_BITS = 8,
   parameter int unsigned LATENCY       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_address,
   input  logic [63:0] mem_wdata,
   output logic        mem_resp,
   output logic [63:0] mem_rdata,
   output logic        protocol_err,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_BURST = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam int unsigned WORDS     = 4 << LINE_IDX_BITS;
   // WAIT lasts LATENCY cycles, so the counter is loaded with LATENCY-1.
   localparam logic [7:0]  WAIT_LOAD = 8'(LATENCY - 1);

   state_e                   state_q, state_d;
   logic                     op_rd_q, op_rd_d;
   logic [LINE_IDX_BITS-1:0] idx_q, idx_d;
   logic [7:0]               wait_q, wait_d;
   logic [1:0]               beat_q, beat_d;

   logic [63:0]              mem_q [WORDS];
   logic [LINE_IDX_BITS+1:0] word_addr;
   logic                     req;
   logic                     wr_en;
   logic                     unused_addr_bits;

   assign req              = mem_read | mem_write;
   assign word_addr        = {idx_q, beat_q};
   assign unused_addr_bits = ^{mem_address[31:5+LINE_IDX_BITS], mem_address[4:0]};

   // Next-state logic: accept, count latency, step beats, wait for the request to drop.
   always_comb begin
      state_d = state_q;
      op_rd_d = op_rd_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      beat_d  = beat_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               op_rd_d = mem_read;              // read wins when both are high
               idx_d   = mem_address[5 +: LINE_IDX_BITS];
               wait_d  = WAIT_LOAD;
               beat_d  = 2'd0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_q == 8'd0) begin
               beat_d  = 2'd0;
               state_d = S_BURST;
            end else begin
               wait_d = wait_q - 8'd1;
            end
         end
         S_BURST: begin
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!req) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and transaction registers; reset aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_rd_q <= 1'b0;
         idx_q   <= '0;
         wait_q  <= 8'd0;
         beat_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         op_rd_q <= op_rd_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         beat_q  <= beat_d;
      end
   end

   // A write beat is committed on the edge that ends its BURST cycle, unless reset is high.
   assign wr_en = (state_q == S_BURST) && !op_rd_q && !rst;

   // Line store: not reset, so committed beats survive an aborted burst.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[word_addr] <= mem_wdata;
      end
   end

   assign mem_resp  = (state_q == S_BURST);
   assign mem_rdata = (state_q == S_BURST && op_rd_q) ? mem_q[word_addr] : 64'd0;
   assign dbg_state = state_q;

`ifdef BURST_MEM_PROTO_CHECK_EN
   logic err_q, err_d;
   logic busy;
   logic viol;

   // Violation detect: both ops high, misaligned accept, early drop, op change mid-transaction.
   always_comb begin
      busy = (state_q == S_WAIT) || (state_q == S_BURST);
      viol = 1'b0;
      if (mem_read && mem_write) begin
         viol = 1'b1;
      end
      if (state_q == S_IDLE && req && mem_address[4:0] != 5'd0) begin
         viol = 1'b1;
      end
      if (busy && !req) begin
         viol = 1'b1;
      end
      if (state_q != S_IDLE && ((op_rd_q && mem_write) || (!op_rd_q && mem_read))) begin
         viol = 1'b1;
      end
      err_d = err_q | viol;
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign protocol_err = err_q;
`else
   assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: a LATENCY=4 instance carries the main tests.
// LATENCY=1 and LATENCY=255 instances cover the latency extremes.
// All three instances share stimulus; sel_lat picks which one is checked.
// A reset precedes every change of sel_lat.
`timescale 1ns/1ps
module tb_burst_mem_responder;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_BURST = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
`ifdef BURST_MEM_PROTO_CHECK_EN
   localparam bit PROTO_EN = 1'b1;
`else
   localparam bit PROTO_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] mem_address = 32'd0;
   logic [63:0] mem_wdata = 64'd0;

   always #5 clk = ~clk;

   logic        resp_a, resp_b, resp_c;
   logic [63:0] rdata_a, rdata_b, rdata_c;
   logic        err_a, err_b, err_c;
   logic [1:0]  st_a, st_b, st_c;

   burst_mem_responder #(.LINE_IDX_BITS(8), .LATENCY(4)) u_dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_resp(resp_a), .mem_rdata(rdata_a), .protocol_err(err_a), .dbg_state(st_a));

   burst_mem_responder #(.LINE_IDX_BITS(8), .LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_resp(resp_b), .mem_rdata(rdata_b), .protocol_err(err_b), .dbg_state(st_b));

   burst_mem_responder #(.LINE_IDX_BITS(8), .LATENCY(255)) u_dut_l255 (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_resp(resp_c), .mem_rdata(rdata_c), .protocol_err(err_c), .dbg_state(st_c));

   int          sel_lat = 4;
   logic        resp;
   logic [63:0] rdata;
   logic        err;
   logic [1:0]  st;

   // Route the instance under test to the checked signals.
   always_comb begin
      case (sel_lat)
         1: begin
            resp = resp_b; rdata = rdata_b; err = err_b; st = st_b;
         end
         255: begin
            resp = resp_c; rdata = rdata_c; err = err_c; st = st_c;
         end
         default: begin
            resp = resp_a; rdata = rdata_a; err = err_a; st = st_a;
         end
      endcase
   end

   // ---------------- scoreboard ----------------
   int          n_vec = 0;
   int          n_bad = 0;
   logic        exp_err = 1'b0;
   logic [63:0] mdl [256][4];
   logic [63:0] wbeats [4];
   logic [63:0] exp_q [$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_err = 1'b0;
      @(negedge clk);
      chk("reset_state", {62'd0, st}, {62'd0, ST_IDLE});
      chk("reset_resp", {63'd0, resp}, 64'd0);
      chk("reset_rdata", rdata, 64'd0);
      chk("reset_err", {63'd0, err}, 64'd0);
   endtask

   // One transaction starting in cycle 0. hold: extra DONE cycles with the request high.
   // drop_at > 0: request low from that cycle on. rst_at >= 0: reset pulsed in that cycle.
   task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input int lat, input int hold, input int drop_at, input int rst_at);
      int          last;
      int          beat;
      logic [7:0]  idx;
      logic        req_on;
      logic        viol;
      logic [1:0]  st_exp;
      logic [63:0] rd_exp;
      last = lat + 5 + hold;
      idx  = addr[12:5];
      beat = 0;
      exp_q.delete();
      for (int c = 0; c <= last; c++) begin
         @(posedge clk); #1;
         if (rst_at >= 0 && c == rst_at + 1) begin
            rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
            @(negedge clk);
            chk("abort_resp", {63'd0, resp}, 64'd0);
            chk("abort_state", {62'd0, st}, {62'd0, ST_IDLE});
            chk("abort_rdata", rdata, 64'd0);
            chk("abort_err", {63'd0, err}, 64'd0);
            return;
         end
         req_on      = (drop_at > 0) ? (c < drop_at) : (c < lat + 5 + hold);
         rst         = (c == rst_at);
         mem_read    = req_on & rd;
         mem_write   = req_on & wr;
         mem_address = addr;
         mem_wdata   = (beat < 4) ? wbeats[beat] : 64'd0;
         if (c == 0)             st_exp = ST_IDLE;
         else if (c <= lat)      st_exp = ST_WAIT;
         else if (c <= lat + 4)  st_exp = ST_BURST;
         else                    st_exp = ST_DONE;
         rd_exp = 64'd0;
         if (st_exp == ST_BURST && rd) begin
            rd_exp = mdl[idx][c - lat - 1];
         end
         exp_q.push_back(rd_exp);
         @(negedge clk);
         chk("state", {62'd0, st}, {62'd0, st_exp});
         chk("resp", {63'd0, resp}, {63'd0, (st_exp == ST_BURST)});
         chk("rdata", rdata, exp_q.pop_front());
         chk("proto_err", {63'd0, err}, {63'd0, exp_err});
         if (st_exp == ST_BURST) begin
            if (!rd && c != rst_at) begin
               mdl[idx][c - lat - 1] = wbeats[c - lat - 1];
            end
            beat++;
         end
         viol = (mem_read & mem_write) | (c == 0 && addr[4:0] != 5'd0) |
                ((st_exp == ST_WAIT || st_exp == ST_BURST) && !req_on);
         if (PROTO_EN && viol) exp_err = 1'b1;
         if (c == rst_at) exp_err = 1'b0;
      end
   endtask

   task automatic set_beats(input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3);
      wbeats[0] = b0; wbeats[1] = b1; wbeats[2] = b2; wbeats[3] = b3;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 256; i++) begin
         for (int k = 0; k < 4; k++) mdl[i][k] = 64'd0;
      end
      set_beats(64'd0, 64'd0, 64'd0, 64'd0);
      do_reset();

      // write then read line 0x40, then a long-held read
      set_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
      do_txn(1'b0, 1'b1, 32'h0000_0040, 4, 0, 0, -1);
      do_txn(1'b1, 1'b0, 32'h0000_0040, 4, 0, 0, -1);
      do_txn(1'b1, 1'b0, 32'h0000_0040, 4, 10, 0, -1);

      // alias: 0x2020 and 0x0020 both map to line 1
      set_beats(64'hA5A5_0000_0000_0001, 64'h5A5A_0000_0000_0002,
                64'hC3C3_0000_0000_0003, 64'h3C3C_0000_0000_0004);
      do_txn(1'b0, 1'b1, 32'h0000_2020, 4, 0, 0, -1);
      do_txn(1'b1, 1'b0, 32'h0000_0020, 4, 0, 0, -1);

      // request dropped in WAIT: all four beats still delivered
      do_txn(1'b1, 1'b0, 32'h0000_0040, 4, 0, 2, -1);

      // both ops high: read is performed
      do_reset();
      do_txn(1'b1, 1'b1, 32'h0000_0040, 4, 0, 0, -1);

      // misaligned address reads line 1
      do_reset();
      do_txn(1'b1, 1'b0, 32'h0000_0024, 4, 0, 0, -1);

      // reset during beat 1 of a write: only beat 0 lands
      do_reset();
      set_beats(64'hDEAD_BEEF_0000_0000, 64'hDEAD_BEEF_0000_0001,
                64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0003);
      do_txn(1'b0, 1'b1, 32'h0000_0040, 4, 0, 0, 6);
      do_txn(1'b1, 1'b0, 32'h0000_0040, 4, 0, 0, -1);
      chk("abort_beat0", mdl[2][0], 64'hDEAD_BEEF_0000_0000);
      chk("abort_beat1", mdl[2][1], 64'h2222_2222_2222_2222);

      // latency extremes
      sel_lat = 1;
      do_reset();
      set_beats(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'h0F0F_0F0F_F0F0_F0F0, 64'h1357_9BDF_2468_ACE0);
      do_txn(1'b0, 1'b1, 32'h0000_1000, 1, 0, 0, -1);
      do_txn(1'b1, 1'b0, 32'h0000_1000, 1, 0, 0, -1);

      sel_lat = 255;
      do_reset();
      set_beats(64'h8000_0000_0000_0001, 64'h4000_0000_0000_0002,
                64'h2000_0000_0000_0004, 64'h1000_0000_0000_0008);
      do_txn(1'b0, 1'b1, 32'h0000_1800, 255, 0, 0, -1);
      do_txn(1'b1, 1'b0, 32'h0000_1800, 255, 0, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // ---------------- timeout ----------------
   initial begin
      #1_000_000;
      $display("FAIL timeout: got no completion expected completion");
      $fatal(1, "timeout");
   end

endmodule
